// File: rtl/cnn_psum_accum.sv
// Per-channel window accumulator with clamping, registered cross-channel adder tree, shift and saturate/truncate output.
// Result valid L+1 edges after the in_last beat (L = clog2(N_CH)); in_ready is low from then until the output handshake.
module cnn_psum_accum #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 12,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int SAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*IN_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_ovf
);

  localparam int L  = (N_CH > 1) ? $clog2(N_CH) : 0;
  localparam int SW = ACC_W + L;
  localparam int LT = (L == 0) ? 1 : L;
  localparam int CW = $clog2(L + 2);
  localparam int MW = ((SW > OUT_W) ? SW : OUT_W) + 1;
  localparam logic [MW-1:0] OMAX = MW'({OUT_W{1'b1}});

  typedef enum logic [1:0] {ACCUM, REDUCE, HOLD} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     rcnt;
  logic              first, ovf, ovf_hit;
  logic              accept, fin;
  logic [ACC_W-1:0]  acc     [N_CH];
  logic [ACC_W-1:0]  acc_nxt [N_CH];
  logic [ACC_W:0]    acc_sum [N_CH];
  logic [SW-1:0]     lvl0    [2*N_CH];
  logic [SW-1:0]     tree    [LT][2*N_CH];
  logic [SW-1:0]     tree_d  [LT][2*N_CH];
  logic [SW-1:0]     sum_full, scaled;
  logic [MW-1:0]     scaled_w;
  logic [OUT_W-1:0]  out_next;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && (state == ACCUM);
  assign fin       = (state == REDUCE) && (rcnt == CW'(L));

  always_comb begin
    state_d = state;
    unique case (state)
      ACCUM:   if (accept && in_last) state_d = REDUCE;
      REDUCE:  if (fin) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      rcnt  <= '0;
    end else begin
      state <= state_d;
      rcnt  <= (state == REDUCE) ? rcnt + 1'b1 : '0;
    end
  end

  // Clamping add: terms are unsigned, so one extra carry bit detects overflow.
  always_comb begin
    ovf_hit = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      acc_sum[c] = {1'b0, acc[c]} + (ACC_W+1)'(in_data[c*IN_W +: IN_W]);
      if (first) begin
        acc_nxt[c] = ACC_W'(in_data[c*IN_W +: IN_W]);
      end else if (acc_sum[c][ACC_W]) begin
        acc_nxt[c] = '1;
        ovf_hit    = 1'b1;
      end else begin
        acc_nxt[c] = acc_sum[c][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first <= 1'b1;
      ovf   <= 1'b0;
      for (int c = 0; c < N_CH; c++) acc[c] <= '0;
    end else begin
      if (accept) begin
        first <= 1'b0;
        ovf   <= ovf | ovf_hit;
        for (int c = 0; c < N_CH; c++) acc[c] <= acc_nxt[c];
      end
      if (state == HOLD && out_ready) begin
        first <= 1'b1;
        ovf   <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2*N_CH; i++) lvl0[i] = '0;
    for (int i = 0; i < N_CH; i++) lvl0[i] = SW'(acc[i]);
  end

  // Level k pairs operands of level k-1; an unpaired last operand passes through.
  always_comb begin
    for (int k = 0; k < LT; k++)
      for (int i = 0; i < 2*N_CH; i++) tree_d[k][i] = '0;
    for (int k = 0; k < L; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (2*i + 1 < ((N_CH + (1 << k) - 1) >> k))
          tree_d[k][i] = ((k == 0) ? lvl0[2*i]   : tree[(k == 0) ? 0 : k-1][2*i])
                       + ((k == 0) ? lvl0[2*i+1] : tree[(k == 0) ? 0 : k-1][2*i+1]);
        else if (2*i < ((N_CH + (1 << k) - 1) >> k))
          tree_d[k][i] = (k == 0) ? lvl0[2*i] : tree[(k == 0) ? 0 : k-1][2*i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LT; k++)
        for (int i = 0; i < 2*N_CH; i++) tree[k][i] <= '0;
    end else begin
      tree <= tree_d;
    end
  end

  assign sum_full = (L == 0) ? lvl0[0] : tree[LT-1][0];
  assign scaled   = sum_full >> SHIFT;
  assign scaled_w = MW'(scaled);

  always_comb begin
    out_next = scaled_w[OUT_W-1:0];
    if (SAT != 0 && scaled_w > OMAX) out_next = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (fin) begin
      out_data <= out_next;
      out_ovf  <= ovf;
    end
  end

endmodule

// File: tb/tb_cnn_psum_accum.sv
// Bench for cnn_psum_accum: table vectors, hand sequences and random windows against a sum/min model.
module tb_cnn_psum_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
  logic [7:0]  od0, od1, od2;

  logic        in_valid3, in_last3, out_ready3, rdy3, ov3, of3;
  logic [7:0]  in_data3, od3;

  cnn_psum_accum u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
                     .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ovf(of0));
  cnn_psum_accum #(.SAT(0)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
                     .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ovf(of1));
  cnn_psum_accum #(.SHIFT(0)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
                     .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ovf(of2));
  cnn_psum_accum #(.N_CH(1), .SHIFT(0)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(rdy3),
                     .in_data(in_data3), .in_last(in_last3), .out_valid(ov3), .out_ready(out_ready3),
                     .out_data(od3), .out_ovf(of3));

  int checks = 0;
  int failures = 0;
  logic [31:0] beats_q[$];

  typedef struct {
    int          nb;
    logic [31:0] d;
    int          e0, e1, e2;
    bit          eo;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, tag, got, exp);
    end
  endtask

  // Clamping per step equals clamping the final sum, since terms are non-negative.
  function automatic void model(input int sh, input bit sat, output int res, output bit ovf);
    longint acc[4];
    longint total;
    for (int c = 0; c < 4; c++) acc[c] = 0;
    foreach (beats_q[b])
      for (int c = 0; c < 4; c++) acc[c] += (beats_q[b] >> (8*c)) & 32'hFF;
    ovf = 0;
    total = 0;
    for (int c = 0; c < 4; c++) begin
      if (acc[c] > 4095) begin
        acc[c] = 4095;
        ovf = 1;
      end
      total += acc[c];
    end
    total = total >> sh;
    res = sat ? int'((total > 255) ? 255 : total) : int'(total % 256);
  endfunction

  task automatic run_window(input string nm, input int e0, input int e1, input int e2, input bit eo, input int hold);
    int lat;
    out_ready = (hold == 0);
    foreach (beats_q[b]) begin
      @(negedge clk);
      if (b == 0) chk(nm, "in_ready", rdy0, 1);
      in_valid = 1'b1;
      in_data  = beats_q[b];
      in_last  = (b == beats_q.size() - 1);
      @(posedge clk);
    end
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      lat++;
    end while (!ov0 && lat < 40);
    chk(nm, "latency", lat - 1, 3);
    chk(nm, "data_sat", od0, e0);
    chk(nm, "data_trunc", od1, e1);
    chk(nm, "data_shift0", od2, e2);
    chk(nm, "ovf", of0, eo);
    chk(nm, "ovf_trunc", of1, eo);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk(nm, "hold_valid", ov0, 1);
      chk(nm, "hold_data", od0, e0);
      chk(nm, "hold_ovf", of0, eo);
      chk(nm, "hold_ready", rdy0, 0);
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = $urandom;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(nm, "post_valid", ov0, 0);
    chk(nm, "post_ready", rdy0, 1);
  endtask

  initial begin
    int e0, e1, e2, nb;
    bit eo;
    int vals[2];

    tbl[0] = '{3,  32'h281E140A, 18,  18,  255, 1'b0};
    tbl[1] = '{20, 32'h000000FF, 255, 255, 255, 1'b1};
    tbl[2] = '{1,  32'h10101010, 4,   4,   64,  1'b0};
    tbl[3] = '{16, 32'hFFFFFFFF, 255, 252, 255, 1'b0};
    tbl[4] = '{1,  32'h04030201, 0,   0,   10,  1'b0};
    vals[0] = 7;
    vals[1] = 9;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_last3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", "out_valid", ov0, 0);
    chk("reset", "out_data", od0, 0);
    chk("reset", "out_ovf", of0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset", "in_ready", rdy0, 1);
    chk("reset", "in_ready_n1", rdy3, 1);

    for (int i = 0; i < 5; i++) begin
      beats_q.delete();
      repeat (tbl[i].nb) beats_q.push_back(tbl[i].d);
      run_window($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].eo, 0);
    end

    beats_q.delete();
    repeat (3) beats_q.push_back(32'h281E140A);
    run_window("backpressure", 18, 18, 255, 1'b0, 5);
    beats_q.delete();
    beats_q.push_back(32'h04030201);
    run_window("bp_next", 0, 0, 10, 1'b0, 0);

    for (int w = 0; w < 30; w++) begin
      beats_q.delete();
      nb = $urandom_range(1, 18);
      repeat (nb) beats_q.push_back($urandom);
      model(4, 1'b1, e0, eo);
      model(4, 1'b0, e1, eo);
      model(0, 1'b1, e2, eo);
      run_window($sformatf("rand%0d", w), e0, e1, e2, eo, $urandom_range(0, 3));
    end

    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h64646464; in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midreset", "out_valid", ov0, 0);
    chk("midreset", "out_data", od0, 0);
    chk("midreset", "out_ovf", of0, 0);
    chk("midreset", "in_ready", rdy0, 1);
    beats_q.delete();
    beats_q.push_back(32'h10101010);
    run_window("after_reset", 4, 4, 64, 1'b0, 0);

    foreach (vals[v]) begin
      @(negedge clk);
      in_valid3 = 1'b1; in_data3 = 8'(vals[v]); in_last3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid3 = 1'b0; in_last3 = 1'b0;
      chk("n1", "reduce_ready", rdy3, 0);
      chk("n1", "reduce_valid", ov3, 0);
      @(negedge clk);
      chk("n1", "valid", ov3, 1);
      chk("n1", "data", od3, vals[v]);
      chk("n1", "hold_ready", rdy3, 0);
      @(negedge clk);
      chk("n1", "ready_back", rdy3, 1);
      chk("n1", "valid_drop", ov3, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_psum_accum.md
# cnn_psum_accum

Parametrised partial-sum accumulator and cross-channel reducer for the CNN datapath. It accepts N_CH per-channel input terms per beat, accumulates one window of terms per channel, then reduces all channel accumulators through a registered adder tree. The result is scaled by a right shift, saturated or truncated, and presented on a valid/ready output. Replaces the fixed 12-bit single-channel accumulator plus 4-input reducer pair, adding depth-agnostic windows, handshakes, saturation and overflow reporting.

## Interface
- N_CH, 4: channel count; any value ≥ 1.
- IN_W, 8: width of each unsigned input term.
- ACC_W, 12: per-channel accumulator width; must be > IN_W.
- OUT_W, 8: output width.
- SHIFT, 4: right-shift applied to the reduced sum.
- SAT, 1: 1 means saturate on output overflow; 0 means truncate to the low OUT_W bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  N_CH*IN_W  channel c occupies bits [c*IN_W +: IN_W].
- in_last  in  1  marks the final beat of a window.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  scaled, reduced window sum.
- out_ovf  out  1  at least one channel accumulator saturated during this window.

## Operation
- States:
  - ACCUM: in_ready = 1.
  - REDUCE: in_ready = 0; lasts L+1 cycles, where L = clog2(N_CH) (L = 0 when N_CH = 1).
  - HOLD: in_ready = 0; out_valid = 1.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
  - First beat of a window: each accumulator loads the zero-extended term.
  - Later beats: each accumulator adds its term.
- Accumulator overflow: if a sum exceeds 2^ACC_W − 1, that accumulator clamps to 2^ACC_W − 1 and the sticky window overflow flag is set.
- ACCUM → REDUCE: on an accepted beat with in_last = 1. A window may be a single beat.
- REDUCE: a pipelined adder tree of L register stages; each level widens the sum by 1 bit, so the full sum is ACC_W+L bits. Odd operands pass through the level unchanged.
- Final stage: s = sum >> SHIFT.
  - SAT = 1: out_data = min(s, 2^OUT_W − 1).
  - SAT = 0: out_data = s[OUT_W−1:0].
  - The output register loads out_data and out_ovf, then the block enters HOLD.
- HOLD → ACCUM: on the edge where out_valid && out_ready. The window-first flag and the overflow flag are rearmed.
- in_valid is ignored while in_ready = 0; there is no buffering.
- Arithmetic is unsigned throughout.

## Timing
- Reset values:
  - in_ready = 1 once state is ACCUM after reset.
  - out_valid = 0, out_data = 0, out_ovf = 0.
  - All accumulators and tree registers = 0.
  - State = ACCUM with the window-first flag set.
- Reset mid-operation (any state): the partial window or pending result is discarded. No output is produced for it.
- Latency: out_valid rises L+1 edges after the edge that accepted the in_last beat. For N_CH = 4 that is 3 edges; for N_CH = 1 it is 1 edge.
- While out_valid = 1 and out_ready = 0: out_data and out_ovf hold stable.
- out_ready high in the same cycle out_valid rises: the handshake completes at that edge.
- in_ready rises the cycle after the output handshake edge.
- Throughput: one window per (beats + L + 2) cycles minimum; windows are never overlapped.
- No combinational path exists from in_* to out_*, or from out_ready to in_ready.

## Test plan
All scenarios use defaults unless noted.

- **Basic window:** 3 beats, channels = 10, 20, 30, 40 each beat, in_last on beat 3, out_ready = 1.
  - Accumulators = 30, 60, 90, 120; sum = 300.
  - out_data = 18, out_ovf = 0; out_valid rises 3 edges after the in_last edge.
- **Accumulator saturation:** 20 beats with ch0 = 255 and other channels = 0.
  - ch0 clamps at 4095; total 4095 >> 4 = 255.
  - out_data = 255, out_ovf = 1.
  - The next window of one beat with all channels = 16 gives out_data = 4, out_ovf = 0 (flag cleared).
- **Output saturation vs truncation:** 16 beats with all channels = 255.
  - Each accumulator = 4080; sum = 16320; 16320 >> 4 = 1020.
  - SAT = 1: out_data = 255.
  - SAT = 0: out_data = 252. out_ovf = 0 in both cases.
- **Backpressure:** hold out_ready low for 5 cycles after out_valid.
  - out_valid, out_data and out_ovf stay stable; in_ready = 0; in_valid pulses are ignored.
  - After the handshake, in_ready = 1 one cycle later.
  - A next window of one beat with channels = 1, 2, 3, 4 and SHIFT = 0 gives out_data = 10 (starts from zero).
- **Reset mid-window:** 2 beats of 100 on all channels, then a 1-cycle rst.
  - Every output is at its reset value in the cycle after rst.
  - A new single-beat window with all channels = 16 gives out_data = 4.
- **N_CH = 1, SHIFT = 0, single-beat windows:** feed terms 7 then 9, each with in_last = 1, out_ready = 1.
  - out_data = 7, then 9; each appears 1 edge after its accept edge.
  - in_ready is low for exactly 2 cycles per window.
